// File: rtl/systolic_sequencer_if.sv
// Bundle of the host configuration, operand stream, array control and result
// stream signals around the systolic array sequencer.
interface systolic_sequencer_if #(
  parameter int N     = 8,
  parameter int LEN_W = 8
);
  logic             cfg_start;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_xor;
  logic             busy;
  logic             done;

  logic             op_valid;
  logic             op_ready;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;

  logic [N-1:0]     arr_in1;
  logic [N-1:0]     arr_in2;
  logic             arr_valid;
  logic             arr_readout;
  logic             arr_clear;
  logic             arr_usexor;
  logic [N-1:0]     arr_out;

  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             res_last;

  // Sequencer side
  modport master (
    input  cfg_start, cfg_len, cfg_xor, op_valid, op_a, op_b, arr_out, res_ready,
    output busy, done, op_ready, arr_in1, arr_in2, arr_valid, arr_readout,
           arr_clear, arr_usexor, res_valid, res_data, res_last
  );

  // Host / array side
  modport slave (
    output cfg_start, cfg_len, cfg_xor, op_valid, op_a, op_b, arr_out, res_ready,
    input  busy, done, op_ready, arr_in1, arr_in2, arr_valid, arr_readout,
           arr_clear, arr_usexor, res_valid, res_data, res_last
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Job sequencer for the systolic array: clear, feed K operand pairs, flush
// with zero pairs, then stream out N result rows under backpressure.
module systolic_sequencer #(
  parameter int N         = 8,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 2*N
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_sequencer_if.master  bus
);
  localparam int P_W = $clog2(N+1);
  localparam int D_W = $clog2(DRAIN_CYC+1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READ} state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] k_reg;
  logic [P_W-1:0]   p_reg;
  logic [D_W-1:0]   drain_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             clear_reg;
  logic             ready_reg;
  logic             usexor_reg;
  logic             res_valid_reg;
  logic             res_last_reg;
  logic [N-1:0]     res_data_reg;

  logic             transfer;
  logic             pulse;

  assign transfer = ready_reg && bus.op_valid;
  // Once the last row sits in the output register no further pulse may fire.
  assign pulse    = (state_reg == READ) &&
                    (!res_valid_reg || (bus.res_ready && !res_last_reg));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      k_reg         <= '0;
      p_reg         <= '0;
      drain_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      clear_reg     <= 1'b0;
      ready_reg     <= 1'b0;
      usexor_reg    <= 1'b0;
      res_valid_reg <= 1'b0;
      res_last_reg  <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      done_reg  <= 1'b0;
      clear_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old job.
          if (bus.cfg_start && !done_reg) begin
            state_reg  <= CLEAR;
            len_reg    <= bus.cfg_len;
            usexor_reg <= bus.cfg_xor;
            busy_reg   <= 1'b1;
            clear_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          k_reg     <= '0;
          p_reg     <= '0;
          drain_reg <= '0;
          if (len_reg != '0) begin
            state_reg <= FEED;
            ready_reg <= 1'b1;
          end else begin
            state_reg <= DRAIN;
          end
        end
        FEED: begin
          if (transfer) begin
            if (k_reg == len_reg - 1'b1) begin
              state_reg <= DRAIN;
              ready_reg <= 1'b0;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_reg == D_W'(DRAIN_CYC - 1)) begin
            state_reg <= READ;
          end else begin
            drain_reg <= drain_reg + 1'b1;
          end
        end
        READ: begin
          if (pulse) begin
            if (p_reg != P_W'(N)) begin
              p_reg <= p_reg + 1'b1;
            end
            // Pulse zero only primes the output chain; its data is stale.
            if (p_reg != '0) begin
              res_data_reg  <= bus.arr_out;
              res_valid_reg <= 1'b1;
              res_last_reg  <= (p_reg == P_W'(N));
            end
          end else if (res_valid_reg && bus.res_ready) begin
            res_valid_reg <= 1'b0;
            if (res_last_reg) begin
              res_last_reg <= 1'b0;
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.op_ready    = ready_reg;
  assign bus.arr_valid   = transfer || (state_reg == DRAIN);
  assign bus.arr_in1     = transfer ? bus.op_a : '0;
  assign bus.arr_in2     = transfer ? bus.op_b : '0;
  assign bus.arr_readout = pulse;
  assign bus.arr_clear   = clear_reg;
  assign bus.arr_usexor  = usexor_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.res_data    = res_data_reg;
  assign bus.res_last    = res_last_reg;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer with a behavioural array stand-in.
module tb_systolic_sequencer;
  localparam int N         = 8;
  localparam int LEN_W     = 8;
  localparam int DRAIN_CYC = 2*N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_sequencer_if #(.N(N), .LEN_W(LEN_W)) bus ();

  systolic_sequencer #(.N(N), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Array stand-in: row i accumulates (a[i] ? b : 0) per valid pair; rows
  // leave bottom-first, with the first readout pulse carrying junk.
  logic [N-1:0] acc [N];
  int rd_cnt;

  always @(posedge clk) begin
    if (bus.arr_clear) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
      rd_cnt <= 0;
    end else begin
      if (bus.arr_valid) begin
        for (int i = 0; i < N; i++)
          acc[i] <= bus.arr_usexor ? (acc[i] ^ (bus.arr_in1[i] ? bus.arr_in2 : '0))
                                   : (acc[i] | (bus.arr_in1[i] ? bus.arr_in2 : '0));
      end
      if (bus.arr_readout) rd_cnt <= rd_cnt + 1;
    end
  end

  always_comb begin
    bus.arr_out = 8'h5A;
    if (bus.arr_readout && rd_cnt >= 1 && rd_cnt <= N) bus.arr_out = acc[N - rd_cnt];
  end

  int n_checks;
  int n_pass;
  logic [N-1:0] pa [256];
  logic [N-1:0] pb [256];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Result row i = fold over pairs of (a[i] ? b : 0) with OR or XOR.
  function automatic logic [N*N-1:0] ref_rows(input int k, input bit x);
    logic [N*N-1:0] r;
    r = '0;
    for (int p = 0; p < k; p++)
      for (int i = 0; i < N; i++)
        if (pa[p][i]) r[i*N +: N] = x ? (r[i*N +: N] ^ pb[p]) : (r[i*N +: N] | pb[p]);
    return r;
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({bus.busy, bus.done, bus.op_ready, bus.arr_valid, bus.arr_readout,
                bus.arr_clear, bus.arr_usexor, bus.res_valid, bus.res_last,
                bus.arr_in1, bus.arr_in2, bus.res_data});
  endfunction

  task automatic run_job(input string nm, input int k, input bit x, input int gap,
                         input int stall_row, input bit rand_ready, input bit start_at_done,
                         input logic [N*N-1:0] exp);
    int idx, rows, vcnt, rdy_cnt, bad, stall_left, last_acc;
    bit finished, stalling;
    logic [N-1:0] held;
    idx = 0; rows = 0; vcnt = 0; rdy_cnt = 0; bad = 0; stall_left = 5;
    last_acc = -10; finished = 1'b0; stalling = 1'b0; held = '0;
    bus.cfg_start = 1'b1;
    bus.cfg_len   = LEN_W'(k);
    bus.cfg_xor   = x;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    check({nm, " clear_cycle"}, 64'({bus.busy, bus.arr_clear}), 64'd3);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      // Starts and config changes while busy must not disturb the job.
      bus.cfg_start = (cyc < 20) && (cyc % 7 == 3);
      bus.cfg_len   = LEN_W'(cyc * 13 + 5);
      bus.cfg_xor   = ~x;
      case (gap)
        0:       bus.op_valid = 1'b1;
        1:       bus.op_valid = (cyc % 2 == 0);
        default: bus.op_valid = 1'($urandom_range(0, 1));
      endcase
      bus.op_a = (idx < 256) ? pa[idx] : '0;
      bus.op_b = (idx < 256) ? pb[idx] : '0;
      stalling = 1'b0;
      if (stall_row >= 0 && rows == stall_row && stall_left > 0 && bus.res_valid) begin
        stalling = 1'b1;
        stall_left--;
        held = bus.res_data;
        bus.res_ready = 1'b0;
      end else begin
        bus.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #4;
      if (bus.op_valid && bus.op_ready) begin
        if (!bus.arr_valid || bus.arr_in1 !== bus.op_a || bus.arr_in2 !== bus.op_b) bad++;
        idx++;
      end else if (bus.arr_in1 != '0 || bus.arr_in2 != '0 || (bus.op_ready && bus.arr_valid)) begin
        bad++;
      end
      if (bus.arr_valid) vcnt++;
      if (bus.op_ready) rdy_cnt++;
      if (bus.arr_readout && bus.arr_valid) bad++;
      if (stalling && (bus.arr_readout || bus.res_data !== held)) bad++;
      if (bus.done) begin
        check({nm, " done_timing"}, 64'(cyc), 64'(last_acc + 1));
        check({nm, " busy_at_done"}, 64'(bus.busy), 64'd0);
        finished = 1'b1;
        if (start_at_done) bus.cfg_start = 1'b1;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (rows < N) begin
          check($sformatf("%s row%0d", nm, rows), 64'(bus.res_data), 64'(exp[(N-1-rows)*N +: N]));
          check($sformatf("%s last%0d", nm, rows), 64'(bus.res_last), 64'(rows == N-1));
        end else begin
          bad++;
        end
        rows++;
        if (rows == N) last_acc = cyc;
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    check({nm, " finished"}, 64'(finished), 64'd1);
    check({nm, " transfers"}, 64'(idx), 64'(k));
    check({nm, " valid_cycles"}, 64'(vcnt), 64'(k + DRAIN_CYC));
    check({nm, " rows"}, 64'(rows), 64'(N));
    check({nm, " invariants"}, 64'(bad), 64'd0);
    if (k == 0) check({nm, " ready_never"}, 64'(rdy_cnt), 64'd0);
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    if (start_at_done) check({nm, " start_at_done_ignored"}, 64'(bus.busy), 64'd0);
    $display("job %s k=%0d xor=%0d transfers=%0d rows=%0d", nm, k, x, idx, rows);
  endtask

  typedef struct {
    int           k;
    bit           x;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           gap;
    int           stall_row;
    logic [N*N-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.cfg_start = 1'b0; bus.cfg_len = '0; bus.cfg_xor = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;

    tbl[0] = '{1,   1'b0, 8'hFF, 8'h01, 0, -1, 64'h0101010101010101};
    tbl[1] = '{0,   1'b0, 8'h00, 8'h00, 0, -1, 64'h0000000000000000};
    tbl[2] = '{2,   1'b1, 8'hFF, 8'hFF, 0, -1, 64'h0000000000000000};
    tbl[3] = '{2,   1'b0, 8'hFF, 8'hFF, 0, -1, 64'hFFFFFFFFFFFFFFFF};
    tbl[4] = '{3,   1'b0, 8'h0F, 8'hF0, 1, -1, 64'h00000000F0F0F0F0};
    tbl[5] = '{3,   1'b0, 8'h0F, 8'hF0, 0, -1, 64'h00000000F0F0F0F0};
    tbl[6] = '{2,   1'b0, 8'hA5, 8'h3C, 0,  3, 64'h3C003C00003C003C};
    tbl[7] = '{255, 1'b1, 8'hFF, 8'h81, 0, -1, 64'h8181818181818181};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 256; p++) begin
        pa[p] = tbl[i].a;
        pb[p] = tbl[i].b;
      end
      run_job($sformatf("tbl%0d", i), tbl[i].k, tbl[i].x, tbl[i].gap,
              tbl[i].stall_row, 1'b0, (i == 0), tbl[i].exp);
    end

    for (int j = 0; j < 8; j++) begin
      int  k;
      bit  x;
      k = $urandom_range(0, 12);
      x = 1'($urandom_range(0, 1));
      for (int p = 0; p < 256; p++) begin
        pa[p] = N'($urandom);
        pb[p] = N'($urandom);
      end
      run_job($sformatf("rnd%0d", j), k, x, 2, -1, 1'b1, 1'b0, ref_rows(k, x));
    end

    // Reset in the middle of FEED.
    bus.cfg_start = 1'b1; bus.cfg_len = 8'd10; bus.cfg_xor = 1'b1; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0; bus.op_valid = 1'b1; bus.op_a = 8'h3C; bus.op_b = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    check("midjob_in_feed", 64'({bus.busy, bus.op_ready, bus.arr_usexor}), 64'd7);
    #1;
    reset = 1'b1;
    #1;
    check("midjob_reset_outputs", out_vec(), 64'd0);
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cfg_start = 1'b0;
    check("reset_release_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    $display("job midjob_reset aborted in FEED");

    for (int p = 0; p < 256; p++) begin
      pa[p] = N'($urandom);
      pb[p] = N'($urandom);
    end
    run_job("post_reset", 6, 1'b0, 2, 2, 1'b0, 1'b0, ref_rows(6, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
